// File: rtl/demux_dispatcher.sv
// One-entry demultiplexing dispatcher: a held beat is presented on exactly one of four channels.
// Optional macro DISPATCH_RR_EN: destination comes from a round-robin pointer instead of in_sel.
module demux_dispatcher #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sel,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [15:0]       beat_cnt
);

  localparam int N_OUT = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        dest_q, dest_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        sel_s;
  logic              in_fire_s;
  logic              out_fire_s;

`ifdef DISPATCH_RR_EN
  logic [1:0] rr_q, rr_d;

  assign sel_s = rr_q;

  // Round-robin pointer moves on every accepted beat, regardless of downstream readiness.
  always_comb begin
    rr_d = rr_q;
    if (in_fire_s) begin
      rr_d = rr_q + 2'd1;
    end else begin
      rr_d = rr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 2'd0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  assign sel_s = in_sel;
`endif

  // In HOLD a new beat is only taken when the held one leaves in the same cycle.
  assign in_ready   = en & ((state_q == IDLE) | out_ready[dest_q]);
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = (state_q == HOLD) & out_ready[dest_q];

  assign out_valid = (state_q == HOLD) ? (4'b0001 << dest_q) : {N_OUT{1'b0}};
  assign out_data  = data_q;
  assign busy      = (state_q == HOLD);
  assign beat_cnt  = cnt_q;

  // Next-state and holding-register update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dest_d  = dest_q;
    cnt_d   = out_fire_s ? (cnt_q + 16'd1) : cnt_q;
    case (state_q)
      IDLE: begin
        if (in_fire_s) begin
          data_d  = in_data;
          dest_d  = sel_s;
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (in_fire_s) begin
          data_d  = in_data;
          dest_d  = sel_s;
          state_d = HOLD;
        end else if (out_fire_s) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, holding register and transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= {DATA_W{1'b0}};
      dest_q  <= 2'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed self-checking bench for demux_dispatcher (select mode by default, RR mode with DISPATCH_RR_EN).
module tb_demux_dispatcher;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic [15:0] beat_cnt;

  int errors = 0;
  int checks = 0;

  demux_dispatcher #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .beat_cnt(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; reset pulse finishes before the next edge.
  task automatic do_reset();
    en = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0; out_ready = 4'b0000;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0; out_ready = 4'b1111;
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got %b exp 0000", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (beat_cnt !== 16'h0000) begin errors++; $display("FAIL reset_beat_cnt got %h exp 0000", beat_cnt); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    rst_n = 1'b1;
    en = 1'b0;
  endtask

  task automatic test_select();
    do_reset();
    en = 1'b1; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h3C; out_ready = 4'b1111;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sel_in_ready_idle got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL sel_out_valid got %b exp 0010", out_valid); end
    checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL sel_out_data got %h exp 3c", out_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sel_busy got %b exp 1", busy); end
    checks++; if (beat_cnt !== 16'd0) begin errors++; $display("FAIL sel_cnt_before got %0d exp 0", beat_cnt); end
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL sel_out_valid_after got %b exp 0000", out_valid); end
    checks++; if (beat_cnt !== 16'd1) begin errors++; $display("FAIL sel_cnt_after got %0d exp 1", beat_cnt); end
    checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL sel_data_retained got %h exp 3c", out_data); end
  endtask

  task automatic test_reset_mid_hold();
    en = 1'b1; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'b0000;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL rmh_held got %b exp 0100", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rmh_out_valid got %b exp 0000", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmh_busy got %b exp 0", busy); end
    checks++; if (beat_cnt !== 16'd0) begin errors++; $display("FAIL rmh_cnt got %0d exp 0", beat_cnt); end
    rst_n = 1'b1;
    out_ready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 4'b0000 || beat_cnt !== 16'd0) begin
        errors++; $display("FAIL rmh_not_delivered got valid=%b cnt=%0d exp 0000/0", out_valid, beat_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    do_reset();
    en = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 8'(i * 17 + 1);
      in_data = d; in_sel = 2'(i % 4);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, in_ready); end
      tick();
      checks++; if (out_valid !== (4'b0001 << (i % 4)) || out_data !== d) begin
        errors++; $display("FAIL b2b_out[%0d] got valid=%b data=%h exp %b/%h", i, out_valid, out_data, 4'b0001 << (i % 4), d);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (beat_cnt !== 16'd8) begin errors++; $display("FAIL b2b_cnt got %0d exp 8", beat_cnt); end
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL b2b_idle got %b exp 0000", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1; in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h5A; out_ready = 4'b0111;
    tick();
    in_data = 8'hC3; in_sel = 2'd0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_other_ready got %b exp 0", in_ready); end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 4'b1000 || out_data !== 8'h5A || in_ready !== 1'b0 || beat_cnt !== 16'd0) begin
        errors++; $display("FAIL bp_hold[%0d] got valid=%b data=%h rdy=%b cnt=%0d exp 1000/5a/0/0", i, out_valid, out_data, in_ready, beat_cnt);
      end
    end
    out_ready = 4'b1111;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_en_low got %b exp 0", in_ready); end
    tick();
    checks++; if (out_valid !== 4'b0000 || busy !== 1'b0 || beat_cnt !== 16'd1) begin
      errors++; $display("FAIL bp_delivered got valid=%b busy=%b cnt=%0d exp 0000/0/1", out_valid, busy, beat_cnt);
    end
    tick();
    checks++; if (out_valid !== 4'b0000 || beat_cnt !== 16'd1) begin
      errors++; $display("FAIL bp_once got valid=%b cnt=%0d exp 0000/1", out_valid, beat_cnt);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_rr();
    logic [1:0] sels [5];
    sels = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd1};
    do_reset();
    en = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_sel = sels[i]; in_data = 8'(8'h40 + i);
      tick();
      checks++; if (out_valid !== (4'b0001 << (i % 4)) || out_data !== 8'(8'h40 + i)) begin
        errors++; $display("FAIL rr_channel[%0d] got %b/%h exp %b/%h", i, out_valid, out_data, 4'b0001 << (i % 4), 8'(8'h40 + i));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    en = 1'b1; out_ready = 4'b1111; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h77;
    repeat (65535) @(posedge clk);
    #1;
    in_valid = 1'b0;
    tick();
    checks++; if (beat_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h exp ffff", beat_cnt); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (beat_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_rollover got %h exp 0000", beat_cnt); end
  endtask

  initial begin
    test_reset();
`ifndef DISPATCH_RR_EN
    test_select();
    test_reset_mid_hold();
`endif
    test_back_to_back();
`ifndef DISPATCH_RR_EN
    test_backpressure();
`else
    test_rr();
`endif
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
